// File: rtl/cr_pipe_unit_if.sv
// ---------------------------------------------------------------------------
// cr_pipe_unit_if
//   Decoder-to-CR-unit op bus. The decoder drives an op and its operands; the
//   CR unit returns op_ready.
//
//   Handshake: an op transfers on a rising clk edge where op_valid and
//   op_ready are both high. While op_valid is high and op_ready is low the
//   master holds the op and its fields stable. op_ready never depends on
//   op_valid.
//
//   Signals (master view):
//     op_valid  out  op present
//     op_ready  in   unit can accept an op this cycle
//     op_code   out  4-bit operation code
//     op_bt     out  target bit (logical ops)
//     op_ba     out  source bit A
//     op_bb     out  source bit B
//     op_bf     out  target field (MCRF/SETF)
//     op_bfa    out  source field (MCRF)
//     op_fxm    out  field mask (MTCRF), bit i selects field i
//     op_fld    out  field data (SETF)
//     op_word   out  whole-register data (MTCRF)
// ---------------------------------------------------------------------------
interface cr_pipe_unit_if #(
   parameter int NFIELD  = 8,
   parameter int FIELD_W = 4
);
   localparam int W  = NFIELD * FIELD_W;
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam int FW = (NFIELD > 1) ? $clog2(NFIELD) : 1;

   logic              op_valid;
   logic              op_ready;
   logic [3:0]        op_code;
   logic [BW-1:0]     op_bt;
   logic [BW-1:0]     op_ba;
   logic [BW-1:0]     op_bb;
   logic [FW-1:0]     op_bf;
   logic [FW-1:0]     op_bfa;
   logic [NFIELD-1:0] op_fxm;
   logic [FIELD_W-1:0] op_fld;
   logic [W-1:0]      op_word;

   modport master (
      output op_valid, op_code, op_bt, op_ba, op_bb, op_bf, op_bfa,
             op_fxm, op_fld, op_word,
      input  op_ready
   );

   modport slave (
      input  op_valid, op_code, op_bt, op_ba, op_bb, op_bf, op_bfa,
             op_fxm, op_fld, op_word,
      output op_ready
   );
endinterface

// File: rtl/cr_pipe_unit.sv
// ---------------------------------------------------------------------------
// cr_pipe_unit
//   Condition-register unit with NFIELD fields of FIELD_W bits. Architectural
//   bit 0 is the MSB; field 0 is architectural bits 0..FIELD_W-1.
//   Two stages: S1 holds the accepted op and reads its operands from the
//   forwarded CR view; S2 computes the write and updates CR on the edge that
//   ends its cycle.
//
//   Ports:
//     clk       in   clock
//     rst_n     in   synchronous reset, active low
//     op        slave side of cr_pipe_unit_if (op_* bus, op_ready)
//     alu_we    in   ALU/MDU write of field 0
//     alu_cr0   in   field-0 data for alu_we
//     stall     in   freeze both stages
//     cr_rd     out  registered CR, architectural bit 0 at the MSB
//     done      out  one-cycle pulse in the cycle after an S2 op retires
//     busy      out  S1 or S2 holds a valid op
// ---------------------------------------------------------------------------
module cr_pipe_unit #(
   parameter int NFIELD  = 8,
   parameter int FIELD_W = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   cr_pipe_unit_if.slave             op,
   input  logic                      alu_we,
   input  logic [FIELD_W-1:0]        alu_cr0,
   input  logic                      stall,
   output logic [NFIELD*FIELD_W-1:0] cr_rd,
   output logic                      done,
   output logic                      busy
);
   localparam int W  = NFIELD * FIELD_W;
   localparam int BW = (W > 1) ? $clog2(W) : 1;
   localparam int FW = (NFIELD > 1) ? $clog2(NFIELD) : 1;

   localparam logic [3:0] OP_AND   = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd2;
   localparam logic [3:0] OP_XOR   = 4'd3;
   localparam logic [3:0] OP_NAND  = 4'd4;
   localparam logic [3:0] OP_NOR   = 4'd5;
   localparam logic [3:0] OP_EQV   = 4'd6;
   localparam logic [3:0] OP_ANDC  = 4'd7;
   localparam logic [3:0] OP_ORC   = 4'd8;
   localparam logic [3:0] OP_MCRF  = 4'd9;
   localparam logic [3:0] OP_SETF  = 4'd10;
   localparam logic [3:0] OP_MTCRF = 4'd11;

   // Architectural register; physical bit W-1 is architectural bit 0.
   logic [W-1:0] cr;
   logic [W-1:0] cr_next;

   // S1: accepted op, raw fields
   logic               s1_v;
   logic [3:0]         s1_code;
   logic [BW-1:0]      s1_bt, s1_ba, s1_bb;
   logic [FW-1:0]      s1_bf, s1_bfa;
   logic [NFIELD-1:0]  s1_fxm;
   logic [FIELD_W-1:0] s1_fld;
   logic [W-1:0]       s1_word;

   // S1 operands read from the forwarded view
   logic               s1_a, s1_b;
   logic [FIELD_W-1:0] s1_src;
   logic [W-1:0]       sh_a, sh_b, sh_f;

   // S2: op plus captured operands
   logic               s2_v;
   logic [3:0]         s2_code;
   logic [BW-1:0]      s2_bt;
   logic [FW-1:0]      s2_bf;
   logic               s2_a, s2_b;
   logic [FIELD_W-1:0] s2_src;
   logic [NFIELD-1:0]  s2_fxm;
   logic [FIELD_W-1:0] s2_fld;
   logic [W-1:0]       s2_word;

   logic               s2_we;
   logic [W-1:0]       s2_wmask, s2_wdata;
   logic [W-1:0]       lop_mask, fld_mask, fld_data;
   logic               lop_hit, lop_bit;

   assign op.op_ready = ~stall;
   assign busy        = s1_v | s2_v;
   assign cr_rd       = cr;
   assign s2_we       = s2_v & ~stall;

   // Next CR value. It doubles as the forwarded view for S1 operand reads:
   // S2 data wins on its bits, then alu_cr0 on field 0, then the register.
   always_comb begin
      cr_next = cr;
      if (alu_we) begin
         cr_next[W-1 -: FIELD_W] = alu_cr0;
      end
      if (s2_we) begin
         cr_next = (cr_next & ~s2_wmask) | (s2_wdata & s2_wmask);
      end
   end

   // S1 operand read; architectural index b lives at physical W-1-b.
   always_comb begin
      sh_a   = cr_next >> (W - 1 - int'(s1_ba));
      sh_b   = cr_next >> (W - 1 - int'(s1_bb));
      sh_f   = cr_next >> ((NFIELD - 1 - int'(s1_bfa)) * FIELD_W);
      s1_a   = sh_a[0];
      s1_b   = sh_b[0];
      s1_src = sh_f[FIELD_W-1:0];
   end

   // Single-bit logical result
   always_comb begin
      lop_hit = 1'b1;
      lop_bit = 1'b0;
      case (s2_code)
         OP_AND:  lop_bit = s2_a & s2_b;
         OP_OR:   lop_bit = s2_a | s2_b;
         OP_XOR:  lop_bit = s2_a ^ s2_b;
         OP_NAND: lop_bit = ~(s2_a & s2_b);
         OP_NOR:  lop_bit = ~(s2_a | s2_b);
         OP_EQV:  lop_bit = ~(s2_a ^ s2_b);
         OP_ANDC: lop_bit = s2_a & ~s2_b;
         OP_ORC:  lop_bit = s2_a | ~s2_b;
         default: lop_hit = 1'b0;
      endcase
      lop_mask = lop_hit ? ({{(W-1){1'b0}}, 1'b1} << (W - 1 - int'(s2_bt))) : '0;
   end

   // Per-field write select and data for MCRF / SETF / MTCRF
   for (genvar g = 0; g < NFIELD; g++) begin : g_fld
      logic               sel;
      logic [FIELD_W-1:0] dat;
      always_comb begin
         sel = 1'b0;
         dat = s2_fld;
         case (s2_code)
            OP_MCRF: begin
               sel = (s2_bf == FW'(g));
               dat = s2_src;
            end
            OP_SETF: begin
               sel = (s2_bf == FW'(g));
               dat = s2_fld;
            end
            OP_MTCRF: begin
               sel = s2_fxm[g];
               dat = s2_word[W-1-g*FIELD_W -: FIELD_W];
            end
            default: ;
         endcase
      end
      assign fld_mask[W-1-g*FIELD_W -: FIELD_W] = {FIELD_W{sel}};
      assign fld_data[W-1-g*FIELD_W -: FIELD_W] = dat;
   end

   // Logical ops and field ops never coexist, so the masks are disjoint.
   assign s2_wmask = lop_mask | fld_mask;
   assign s2_wdata = (lop_mask & {W{lop_bit}}) | (fld_mask & fld_data);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cr      <= '0;
         done    <= 1'b0;
         s1_v    <= 1'b0;
         s1_code <= '0;
         s1_bt   <= '0;
         s1_ba   <= '0;
         s1_bb   <= '0;
         s1_bf   <= '0;
         s1_bfa  <= '0;
         s1_fxm  <= '0;
         s1_fld  <= '0;
         s1_word <= '0;
         s2_v    <= 1'b0;
         s2_code <= '0;
         s2_bt   <= '0;
         s2_bf   <= '0;
         s2_a    <= 1'b0;
         s2_b    <= 1'b0;
         s2_src  <= '0;
         s2_fxm  <= '0;
         s2_fld  <= '0;
         s2_word <= '0;
      end else begin
         cr   <= cr_next;
         done <= s2_we;
         if (!stall) begin
            // op_ready is ~stall, so op_valid alone marks an accept here.
            s1_v    <= op.op_valid;
            s1_code <= op.op_code;
            s1_bt   <= op.op_bt;
            s1_ba   <= op.op_ba;
            s1_bb   <= op.op_bb;
            s1_bf   <= op.op_bf;
            s1_bfa  <= op.op_bfa;
            s1_fxm  <= op.op_fxm;
            s1_fld  <= op.op_fld;
            s1_word <= op.op_word;
            s2_v    <= s1_v;
            s2_code <= s1_code;
            s2_bt   <= s1_bt;
            s2_bf   <= s1_bf;
            s2_a    <= s1_a;
            s2_b    <= s1_b;
            s2_src  <= s1_src;
            s2_fxm  <= s1_fxm;
            s2_fld  <= s1_fld;
            s2_word <= s1_word;
         end
      end
   end
endmodule

// File: tb/tb_cr_pipe_unit.sv
module tb_cr_pipe_unit;
   localparam int NF  = 8;
   localparam int FWD = 4;
   localparam int W   = NF * FWD;

   typedef struct packed {
      logic [3:0]  code;
      logic [4:0]  bt;
      logic [4:0]  ba;
      logic [4:0]  bb;
      logic [2:0]  bf;
      logic [2:0]  bfa;
      logic [7:0]  fxm;
      logic [3:0]  fld;
      logic [31:0] word;
   } op_t;

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         alu_we = 1'b0;
   logic [3:0]   alu_cr0 = 4'h0;
   logic         stall = 1'b0;
   logic [W-1:0] cr_rd;
   logic         done;
   logic         busy;

   always #5 clk = ~clk;

   cr_pipe_unit_if #(.NFIELD(NF), .FIELD_W(FWD)) opif ();

   cr_pipe_unit #(.NFIELD(NF), .FIELD_W(FWD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .op      (opif),
      .alu_we  (alu_we),
      .alu_cr0 (alu_cr0),
      .stall   (stall),
      .cr_rd   (cr_rd),
      .done    (done),
      .busy    (busy)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Result of one op applied to a CR value, as (mask, data) over the word.
   function automatic void exec_op(input logic [31:0] cr, input op_t o,
                                   output logic [31:0] m, output logic [31:0] d);
      int a, b, r;
      logic [31:0] f;
      m = 32'h0;
      d = 32'h0;
      a = int'((cr >> (31 - int'(o.ba))) & 32'h1);
      b = int'((cr >> (31 - int'(o.bb))) & 32'h1);
      r = 0;
      case (o.code)
         4'd1: r = a & b;
         4'd2: r = a | b;
         4'd3: r = a ^ b;
         4'd4: r = 1 - (a & b);
         4'd5: r = 1 - (a | b);
         4'd6: r = 1 - (a ^ b);
         4'd7: r = a & (1 - b);
         4'd8: r = a | (1 - b);
         default: r = 0;
      endcase
      if (o.code >= 4'd1 && o.code <= 4'd8) begin
         m = 32'h1 << (31 - int'(o.bt));
         d = (r != 0) ? m : 32'h0;
      end else if (o.code == 4'd9) begin
         f = (cr >> (4 * (7 - int'(o.bfa)))) & 32'hF;
         m = 32'hF << (4 * (7 - int'(o.bf)));
         d = f << (4 * (7 - int'(o.bf)));
      end else if (o.code == 4'd10) begin
         m = 32'hF << (4 * (7 - int'(o.bf)));
         d = {28'h0, o.fld} << (4 * (7 - int'(o.bf)));
      end else if (o.code == 4'd11) begin
         for (int i = 0; i < 8; i++)
            if (o.fxm[i]) m = m | (32'hF << (4 * (7 - i)));
         d = o.word & m;
      end
   endfunction

   op_t          s1_q[$];
   logic [W-1:0] mask_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_cr = '0;
   logic         exp_done = 1'b0;
   bit           model_ok = 1'b0;
   logic [W-1:0] mk, dt;
   op_t          mo, cur;

   // Each op takes its operands from the CR as it stands right after the edge
   // it leaves S1 on, and lands one non-stalled edge later.
   always @(posedge clk) begin
      if (!rst_n) begin
         s1_q.delete();
         mask_q.delete();
         exp_q.delete();
         m_cr     = '0;
         exp_done = 1'b0;
         model_ok = 1'b1;
      end else begin
         if (alu_we) m_cr = {alu_cr0, m_cr[27:0]};
         exp_done = 1'b0;
         if (!stall) begin
            if (mask_q.size() > 0) begin
               mk = mask_q.pop_front();
               dt = exp_q.pop_front();
               m_cr = (m_cr & ~mk) | (dt & mk);
               exp_done = 1'b1;
            end
            if (s1_q.size() > 0) begin
               mo = s1_q.pop_front();
               exec_op(m_cr, mo, mk, dt);
               mask_q.push_back(mk);
               exp_q.push_back(dt);
            end
            if (opif.op_valid) begin
               cur = '{code: opif.op_code, bt: opif.op_bt, ba: opif.op_ba, bb: opif.op_bb,
                       bf: opif.op_bf, bfa: opif.op_bfa, fxm: opif.op_fxm,
                       fld: opif.op_fld, word: opif.op_word};
               s1_q.push_back(cur);
            end
         end
      end
   end

   // Every-cycle comparison on the falling edge
   always @(negedge clk) begin
      if (model_ok) begin
         check("cr_rd", cr_rd, m_cr);
         check("done", W'(done), W'(exp_done));
         check("busy", W'(busy), W'((s1_q.size() + mask_q.size()) != 0));
         check("op_ready", W'(opif.op_ready), W'(!stall));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic issue(input op_t o);
      opif.op_valid = 1'b1;
      opif.op_code  = o.code;
      opif.op_bt    = o.bt;
      opif.op_ba    = o.ba;
      opif.op_bb    = o.bb;
      opif.op_bf    = o.bf;
      opif.op_bfa   = o.bfa;
      opif.op_fxm   = o.fxm;
      opif.op_fld   = o.fld;
      opif.op_word  = o.word;
      step();
      opif.op_valid = 1'b0;
   endtask

   function automatic op_t mk_op(input logic [3:0] code, input logic [4:0] bt, input logic [4:0] ba,
                                 input logic [4:0] bb, input logic [2:0] bf, input logic [2:0] bfa,
                                 input logic [7:0] fxm, input logic [3:0] fld, input logic [31:0] word);
      op_t o;
      o = '{code: code, bt: bt, ba: ba, bb: bb, bf: bf, bfa: bfa, fxm: fxm, fld: fld, word: word};
      return o;
   endfunction

   function automatic op_t mtcrf(input logic [7:0] fxm, input logic [31:0] word);
      return mk_op(4'd11, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, fxm, 4'h0, word);
   endfunction

   // ---------------- directed scenarios ----------------
   initial begin
      opif.op_valid = 1'b0;
      opif.op_code  = 4'h0;
      opif.op_bt    = '0;
      opif.op_ba    = '0;
      opif.op_bb    = '0;
      opif.op_bf    = '0;
      opif.op_bfa   = '0;
      opif.op_fxm   = '0;
      opif.op_fld   = '0;
      opif.op_word  = '0;
      steps(2);
      check("reset_cr", cr_rd, 32'h0);
      check("reset_busy", W'(busy), 32'h0);
      rst_n = 1'b1;

      // 1: full-word MTCRF, two-edge latency, single done pulse
      issue(mtcrf(8'hFF, 32'hA5A5_A5A5));
      step();
      check("t1_not_yet", cr_rd, 32'h0);
      step();
      check("t1_cr", cr_rd, 32'hA5A5_A5A5);
      check("t1_model", m_cr, 32'hA5A5_A5A5);
      check("t1_done", W'(done), 32'h1);
      step();
      check("t1_done_once", W'(done), 32'h0);

      // 2: SETF then dependent OR back-to-back (forwarded A)
      issue(mtcrf(8'hFF, 32'h0));
      steps(3);
      issue(mk_op(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 8'h0, 4'b1000, 32'h0));
      issue(mk_op(4'd2, 5'd1, 5'd0, 5'd5, 3'd0, 3'd0, 8'h0, 4'h0, 32'h0));
      steps(3);
      check("t2_fwd_or", cr_rd, 32'hC000_0000);

      // 3: MCRF right behind the MTCRF that produces its source
      issue(mtcrf(8'hFF, 32'h1234_5678));
      issue(mk_op(4'd9, 5'd0, 5'd0, 5'd0, 3'd7, 3'd0, 8'h0, 4'h0, 32'h0));
      steps(3);
      check("t3_mcrf", cr_rd, 32'h1234_5671);

      // 4: S2 SETF and alu_we on field 0 in the same cycle, then alu alone
      issue(mk_op(4'd10, 5'd0, 5'd0, 5'd0, 3'd0, 3'd0, 8'h0, 4'hF, 32'h0));
      step();
      alu_we  = 1'b1;
      alu_cr0 = 4'h2;
      step();
      check("t4_s2_wins", cr_rd, 32'hF234_5671);
      step();
      alu_we = 1'b0;
      check("t4_alu_alone", cr_rd, 32'h2234_5671);
      step();

      // 5: stall holds S1 for three cycles
      issue(mk_op(4'd1, 5'd4, 5'd2, 5'd2, 3'd0, 3'd0, 8'h0, 4'h0, 32'h0));
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t5_ready_low", W'(opif.op_ready), 32'h0);
         check("t5_cr_hold", cr_rd, 32'h2234_5671);
         check("t5_no_done", W'(done), 32'h0);
      end
      stall = 1'b0;
      step();
      check("t5_one_edge", cr_rd, 32'h2234_5671);
      step();
      check("t5_written", cr_rd, 32'h2A34_5671);
      check("t5_done", W'(done), 32'h1);

      // Every logical op plus reserved/NOP, back-to-back, A=1 B=0
      issue(mtcrf(8'hFF, 32'hA000_0000));
      steps(3);
      for (int c = 1; c <= 8; c++)
         issue(mk_op(4'(c), 5'(8 + c), 5'd0, 5'd1, 3'd0, 3'd0, 8'h0, 4'h0, 32'h0));
      issue(mk_op(4'd13, 5'd20, 5'd0, 5'd1, 3'd2, 3'd0, 8'hFF, 4'hF, 32'hFFFF_FFFF));
      issue(mk_op(4'd0, 5'd21, 5'd0, 5'd1, 3'd2, 3'd0, 8'hFF, 4'hF, 32'hFFFF_FFFF));
      steps(3);
      check("logic_table", cr_rd, 32'hA039_8000);

      // MCRF whose source field 0 is written by the ALU as it leaves S1
      issue(mk_op(4'd9, 5'd0, 5'd0, 5'd0, 3'd5, 3'd0, 8'h0, 4'h0, 32'h0));
      alu_we  = 1'b1;
      alu_cr0 = 4'h9;
      step();
      alu_we = 1'b0;
      step();
      check("alu_fwd_mcrf", cr_rd, 32'h9039_8900);
      steps(2);

      // 6: reset with an MTCRF in flight, then a masked MTCRF
      issue(mtcrf(8'hFF, 32'hDEAD_BEEF));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("t6_cr", cr_rd, 32'h0);
      check("t6_busy", W'(busy), 32'h0);
      check("t6_done", W'(done), 32'h0);
      steps(2);
      check("t6_discarded", cr_rd, 32'h0);
      check("t6_no_done", W'(done), 32'h0);
      issue(mtcrf(8'h01, 32'hF000_0000));
      steps(2);
      check("t6_mtcrf", cr_rd, 32'hF000_0000);
      steps(3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
